// File: rtl/rv_cache_bus_master_if.sv
// Cache-side request/response and Wishbone-classic signals of the cache bus master,
// bundled so the master and its neighbours share one connection.
interface rv_cache_bus_master_if;
    logic [31:0] i_addr;
    logic        i_read;
    logic        i_write;
    logic        i_miss;
    logic [3:0]  i_write_sel;
    logic [31:0] i_write_data;
    logic [31:0] o_bus_data;
    logic        o_bus_ack;
    logic        o_err;
    logic        o_busy;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_adr;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_dat;
    logic [31:0] i_wb_dat;
    logic        i_wb_ack;
    logic        i_wb_err;

    modport master (
        input  i_addr, i_read, i_write, i_miss, i_write_sel, i_write_data,
        input  i_wb_dat, i_wb_ack, i_wb_err,
        output o_bus_data, o_bus_ack, o_err, o_busy,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_sel, o_wb_dat
    );

    modport slave (
        output i_addr, i_read, i_write, i_miss, i_write_sel, i_write_data,
        output i_wb_dat, i_wb_ack, i_wb_err,
        input  o_bus_data, o_bus_ack, o_err, o_busy,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_sel, o_wb_dat
    );
endinterface

// File: rtl/rv_cache_bus_master.sv
// Turns a cache miss/write request into one single-word Wishbone-classic transaction
// and hands back read data with a one-cycle acknowledge; writes may be posted.
module rv_cache_bus_master #(
    parameter bit POSTED_WRITES  = 1'b1,
    parameter int TIMEOUT_BIT    = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                   i_clk,
    input logic                   i_reset,
    rv_cache_bus_master_if.master bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RD_BUS = 2'd1;
    localparam logic [1:0] WR_BUS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [TIMEOUT_BIT-1:0] cnt_q, cnt_d;
    logic                   cyc_q, cyc_d;
    logic                   we_q, we_d;
    logic [31:0]            adr_q, adr_d;
    logic [3:0]             sel_q, sel_d;
    logic [31:0]            dat_q, dat_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   pack_q, pack_d;
    logic                   rerr_q, rerr_d;

    logic accept;
    logic in_bus;
    logic timeout_hit;
    logic term_err;
    logic term;
    logic posted_wr;

    assign accept      = (state_q == IDLE) && bus.i_miss && (bus.i_read || bus.i_write);
    assign in_bus      = (state_q == RD_BUS) || (state_q == WR_BUS);
    assign timeout_hit = (cnt_q == TIMEOUT_BIT'(TIMEOUT_CYCLES - 1));
    // An ack on the very cycle the counter would expire still wins over the timeout.
    assign term_err    = in_bus && (bus.i_wb_err || (!bus.i_wb_ack && timeout_hit));
    assign term        = in_bus && (bus.i_wb_ack || term_err);
    assign posted_wr   = POSTED_WRITES && (state_q == WR_BUS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        pack_d  = 1'b0;
        rerr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = bus.i_write;
                    adr_d   = bus.i_addr & 32'hFFFF_FFFC;
                    sel_d   = bus.i_write ? bus.i_write_sel : 4'hF;
                    dat_d   = bus.i_write_data;
                    cnt_d   = '0;
                    cyc_d   = 1'b1;
                    pack_d  = bus.i_write && POSTED_WRITES;
                    state_d = bus.i_write ? WR_BUS : RD_BUS;
                end
            end
            RD_BUS, WR_BUS: begin
                if (term) begin
                    cyc_d = 1'b0;
                    if (posted_wr) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                        rerr_d  = term_err;
                        rdata_d = (state_q == RD_BUS && !term_err) ? bus.i_wb_dat : 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + TIMEOUT_BIT'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'h0;
            sel_q   <= 4'h0;
            dat_q   <= 32'h0;
            rdata_q <= 32'h0;
            pack_q  <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            pack_q  <= pack_d;
            rerr_q  <= rerr_d;
        end
    end

    // A posted write reports its bus error while still draining, so o_err never lands in IDLE.
    assign bus.o_err      = ((state_q == RESP) && rerr_q) || (posted_wr && term_err);
    assign bus.o_bus_ack  = pack_q || (state_q == RESP);
    assign bus.o_bus_data = rdata_q;
    assign bus.o_busy     = (state_q != IDLE);
    assign bus.o_wb_cyc   = cyc_q;
    assign bus.o_wb_stb   = cyc_q;
    assign bus.o_wb_we    = we_q;
    assign bus.o_wb_adr   = adr_q;
    assign bus.o_wb_sel   = sel_q;
    assign bus.o_wb_dat   = dat_q;

endmodule
